// File: rtl/special_alu_cmd_issuer_if.sv
// Signal bundle between the host/ALU side and special_alu_cmd_issuer.
// The slave modport is the issuer's view; master is the view of whoever drives it.
interface special_alu_cmd_issuer_if #(
   parameter int AW = 2
);
   logic          a_valid;
   logic          a_ready;
   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_op;
   logic          b_valid;
   logic          b_ready;
   logic [2:0]    b_operation;
   logic [10:0]   b_result;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    out_op;
   logic [10:0]   out_result;
   logic [3:0]    out_cnt;
   logic [AW:0]   out_level;

   modport slave (
      input  a_valid, a_ready, req_valid, req_op, b_ready, b_result, out_ready,
      output req_ready, b_valid, b_operation, out_valid, out_op, out_result,
             out_cnt, out_level
   );

   modport master (
      output a_valid, a_ready, req_valid, req_op, b_ready, b_result, out_ready,
      input  req_ready, b_valid, b_operation, out_valid, out_op, out_result,
             out_cnt, out_level
   );
endinterface

// File: rtl/special_alu_cmd_issuer.sv
// Issues host opcodes one at a time on the ALU b-side and buffers each result,
// tagged with opcode and operand-store occupancy, in a credit-checked FIFO.
module special_alu_cmd_issuer #(
   parameter int DEPTH     = 4,
   parameter int AW        = 2,
   parameter int STORE_MAX = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   special_alu_cmd_issuer_if.slave  bus
);

   if (AW != $clog2(DEPTH) || DEPTH < 2 || DEPTH > 16) begin : g_param_check
      $error("special_alu_cmd_issuer: AW must equal log2(DEPTH), DEPTH in 2..16");
   end

   localparam logic [AW:0] DEPTH_L     = (AW+1)'(DEPTH);
   localparam logic [3:0]  STORE_MAX_L = 4'(STORE_MAX);

   typedef enum logic {IDLE, ISSUE} state_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [10:0] result;
      logic [3:0]  cnt;
   } entry_t;

   state_t        state, state_nxt;
   logic          run;
   logic [2:0]    op_q;
   logic [3:0]    occ;
   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level;

   logic a_hs, req_hs, b_hs, pop;

   assign a_hs   = bus.a_valid & bus.a_ready;
   assign req_hs = bus.req_valid & bus.req_ready;
   assign b_hs   = bus.b_valid & bus.b_ready;
   assign pop    = bus.out_valid & bus.out_ready;

   // run holds req_ready low until the first edge after reset is released.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         run   <= 1'b0;
         op_q  <= 3'd0;
      end else begin
         state <= state_nxt;
         run   <= 1'b1;
         if (req_hs) op_q <= bus.req_op;
      end
   end

   // NOTE: defaults first so no path through the block leaves a signal unassigned
   // (which would infer a latch).
   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      unique case (state)
         IDLE: begin
            bus.req_ready = run && (level < DEPTH_L);
            if (bus.req_valid && run && (level < DEPTH_L)) state_nxt = ISSUE;
         end
         ISSUE: begin
            if (bus.b_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.b_valid     = (state == ISSUE);
   assign bus.b_operation = op_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         occ <= 4'd0;
      end else if (a_hs && !b_hs) begin
         if (occ < STORE_MAX_L) occ <= occ + 4'd1;
      end else if (!a_hs && b_hs) begin
         if (occ != 4'd0) occ <= occ - 4'd1;
      end
   end

   // NOTE: storage is not reset; the pointers and level alone define validity.
   always_ff @(posedge clk) begin
      if (b_hs) mem[wr_ptr] <= '{op: op_q, result: bus.b_result, cnt: occ};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (b_hs) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({b_hs, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   assign bus.out_valid  = (level != '0);
   assign bus.out_op     = mem[rd_ptr].op;
   assign bus.out_result = mem[rd_ptr].result;
   assign bus.out_cnt    = mem[rd_ptr].cnt;
   assign bus.out_level  = level;

endmodule

// File: tb/tb_special_alu_cmd_issuer.sv
// Directed bench for special_alu_cmd_issuer: stimulus pushes expected tagged
// results into a queue, a negedge monitor pops and compares on each output pop.
module tb_special_alu_cmd_issuer;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   typedef struct packed {
      logic [2:0]  op;
      logic [10:0] result;
      logic [3:0]  cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   special_alu_cmd_issuer_if #(.AW(AW)) bus ();

   special_alu_cmd_issuer #(.DEPTH(DEPTH), .AW(AW), .STORE_MAX(8)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Head is compared on the negedge before the edge that pops it.
   always @(negedge clk) begin
      if (rstn && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("sb_underrun", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_op", 32'(bus.out_op), 32'(e.op));
            check("out_result", 32'(bus.out_result), 32'(e.result));
            check("out_cnt", 32'(bus.out_cnt), 32'(e.cnt));
         end
      end
   end

   task automatic a_pulses(input int n);
      bus.a_valid = 1'b1;
      bus.a_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      bus.a_valid = 1'b0;
      bus.a_ready = 1'b0;
   endtask

   // Returns at +1 after the request handshake edge.
   task automatic do_req(input logic [2:0] op);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      while (!bus.req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) check("req_ready_timeout", 32'd0, 32'd1);
      check("b_valid_pre_hs", 32'(bus.b_valid), 32'd0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("b_valid_after_req", 32'(bus.b_valid), 32'd1);
      check("b_operation", 32'(bus.b_operation), 32'(op));
   endtask

   task automatic do_op(input logic [2:0] op, input logic [10:0] res, input logic [3:0] cnt,
                        input int stall, input bit a_on_b, input bit pop_on_b);
      do_req(op);
      bus.b_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         check("stall_b_valid", 32'(bus.b_valid), 32'd1);
         check("stall_b_operation", 32'(bus.b_operation), 32'(op));
      end
      bus.b_result = res;
      bus.b_ready  = 1'b1;
      if (a_on_b) begin
         bus.a_valid = 1'b1;
         bus.a_ready = 1'b1;
      end
      if (pop_on_b) bus.out_ready = 1'b1;
      sb.push_back('{op: op, result: res, cnt: cnt});
      @(posedge clk); #1;
      bus.b_ready = 1'b0;
      bus.a_valid = 1'b0;
      bus.a_ready = 1'b0;
      if (pop_on_b) bus.out_ready = 1'b0;
      check("b_valid_after_b_hs", 32'(bus.b_valid), 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      bus.out_ready = 1'b1;
      while (bus.out_level != '0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_level", 32'(bus.out_level), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn          = 1'b0;
      bus.a_valid   = 1'b0;
      bus.a_ready   = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.b_ready   = 1'b0;
      bus.b_result  = 11'd0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_b_valid", 32'(bus.b_valid), 32'd0);
      check("rst_b_operation", 32'(bus.b_operation), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_level", 32'(bus.out_level), 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

      // Single SUM after three operands: tag 3, occ drops to 2.
      a_pulses(3);
      do_op(3'd6, 11'h060, 4'd3, 0, 1'b0, 1'b0);
      check("t1_out_valid", 32'(bus.out_valid), 32'd1);
      check("t1_out_level", 32'(bus.out_level), 32'd1);
      do_op(3'd1, 11'h011, 4'd2, 0, 1'b0, 1'b0);
      drain();

      // Back-pressure: four buffered results block further requests.
      bus.out_ready = 1'b0;
      do_op(3'd2, 11'h101, 4'd1, 0, 1'b0, 1'b0);
      do_op(3'd3, 11'h202, 4'd0, 0, 1'b0, 1'b0);
      do_op(3'd4, 11'h303, 4'd0, 0, 1'b0, 1'b0);
      do_op(3'd5, 11'h404, 4'd0, 0, 1'b0, 1'b0);
      check("bp_level_full", 32'(bus.out_level), 32'd4);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd1;
      @(posedge clk); #1;
      check("bp_req_ready_full", 32'(bus.req_ready), 32'd0);
      check("bp_level_held", 32'(bus.out_level), 32'd4);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("bp_req_ready_after_pop", 32'(bus.req_ready), 32'd1);
      check("bp_level_after_pop", 32'(bus.out_level), 32'd3);
      bus.req_valid = 1'b0;
      drain();

      // b_ready stall of five cycles, exactly one push.
      bus.out_ready = 1'b0;
      do_op(3'd7, 11'h7FF, 4'd0, 5, 1'b0, 1'b0);
      check("stall_one_push", 32'(bus.out_level), 32'd1);
      drain();

      // Saturation at 8, then countdown to 0 with no underflow.
      a_pulses(10);
      for (int i = 0; i < 10; i++) begin
         do_op(3'd0, 11'(i + 'h40), (i <= 8) ? 4'(8 - i) : 4'd0, 0, 1'b0, 1'b0);
      end
      drain();

      // Simultaneous a/b handshake keeps occ at 5.
      a_pulses(5);
      do_op(3'd1, 11'h055, 4'd5, 0, 1'b1, 1'b0);
      do_op(3'd2, 11'h066, 4'd5, 0, 1'b0, 1'b0);
      drain();

      // Simultaneous push and pop at level 2.
      bus.out_ready = 1'b0;
      do_op(3'd3, 11'h0AA, 4'd4, 0, 1'b0, 1'b0);
      do_op(3'd4, 11'h0BB, 4'd3, 0, 1'b0, 1'b0);
      check("pp_level_before", 32'(bus.out_level), 32'd2);
      do_op(3'd5, 11'h0CC, 4'd2, 0, 1'b0, 1'b1);
      check("pp_level_after", 32'(bus.out_level), 32'd2);
      drain();

      // Reset in ISSUE with three entries buffered.
      bus.out_ready = 1'b0;
      do_op(3'd6, 11'h123, 4'd1, 0, 1'b0, 1'b0);
      do_op(3'd7, 11'h234, 4'd0, 0, 1'b0, 1'b0);
      do_op(3'd0, 11'h345, 4'd0, 0, 1'b0, 1'b0);
      check("mr_level", 32'(bus.out_level), 32'd3);
      do_req(3'd1);
      rstn = 1'b0;
      #1;
      sb.delete();
      check("mr_b_valid", 32'(bus.b_valid), 32'd0);
      check("mr_out_valid", 32'(bus.out_valid), 32'd0);
      check("mr_out_level", 32'(bus.out_level), 32'd0);
      check("mr_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      #1;
      check("mr_req_ready_released", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      check("mr_req_ready_first_edge", 32'(bus.req_ready), 32'd1);
      bus.out_ready = 1'b1;
      do_op(3'd2, 11'h3AB, 4'd0, 0, 1'b0, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/special_alu_cmd_issuer.md
Name: special_alu_cmd_issuer

Overview:
- Downstream consumer of the special_alu b-side (result) interface.
- Accepts operation requests from a host stream and issues them one at a time on the b interface.
- Captures each b_result on its handshake and tags it with the opcode and with the ALU operand-store occupancy at issue time. The occupancy is tracked by monitoring a-side handshakes.
- Buffers tagged results in a small FIFO toward the host, with credit-based back-pressure so no result is ever dropped.

Parameters:
- DEPTH, 4, result FIFO depth; power of two, 2..16.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).
- STORE_MAX, 8, capacity of the ALU operand store; saturation limit of the occupancy monitor.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset; asynchronous assert, active-low
- a_valid  in  1  monitor of ALU a-side valid
- a_ready  in  1  monitor of ALU a-side ready
- req_valid  in  1  host request valid
- req_ready  out  1  host request ready
- req_op  in  3  requested opcode (0 ADD2 .. 7 AVG)
- b_valid  out  1  operation valid to ALU
- b_ready  in  1  ALU accepts operation; result valid in the same cycle
- b_operation  out  3  opcode to ALU
- b_result  in  11  ALU result, sampled on b handshake
- out_valid  out  1  tagged result available
- out_ready  in  1  host consumes result
- out_op  out  3  opcode of head result
- out_result  out  11  head result
- out_cnt  out  4  ALU occupancy (0..8) when the head result was issued
- out_level  out  AW+1  FIFO fill level, 0..DEPTH

Behaviour:
- Reset (async, rstn=0) clears:
  - FSM to IDLE.
  - b_valid=0, b_operation=0.
  - FIFO pointers and level to 0, so out_valid=0 and out_level=0.
  - occ=0.
  - req_ready=0 while rstn=0.
- Reset mid-operation discards any held request and all buffered results. It is not an error.
- Handshakes occur when valid&ready are high on a rising edge.
  - b_valid and b_operation are registered and stable until b_ready.
  - b_valid never drops without a handshake.
- FSM IDLE:
  - req_ready = (out_level + 0 < DEPTH); this reserves the slot for the in-flight result.
  - On req handshake: latch req_op into b_operation, set b_valid=1, go ISSUE. b_valid rises the cycle after the req handshake.
- FSM ISSUE:
  - req_ready=0.
  - On b handshake: push {b_operation, b_result, occ} into the FIFO at that edge, clear b_valid, return to IDLE.
  - The first new request can be accepted the cycle after the b handshake. Throughput is one op per 2 cycles minimum.
- Push is always legal: the slot was reserved at request acceptance.
- Pop occurs on out_valid & out_ready.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Pop on an empty FIFO is impossible because out_valid=0. Pointers wrap modulo DEPTH.
- out_valid = (out_level != 0). out_op, out_result and out_cnt show the head entry, combinationally from storage; no extra latency.
- Push-to-visible latency is one cycle: the entry is pushed at the handshake edge and out_valid is seen the following cycle.
- Occupancy monitor occ (4 bits), per edge; a_hs = a_valid&a_ready, b_hs = b_valid&b_ready:
  - a_hs & !b_hs: occ = min(occ+1, STORE_MAX).
  - !a_hs & b_hs: occ = max(occ-1, 0); no underflow.
  - a_hs & b_hs: occ unchanged.
- The tag captured on push is occ before that edge's update. This is the operand count the ALU computed over.
- Widths:
  - b_result is stored unmodified in 11 bits.
  - out_cnt is zero-extended to 4 bits and saturates at 8.

Test Plan:
- Reset then a single request: 3 a_hs (operands 0x10, 0x20, 0x30), then req_op=6 (SUM), b_ready high at once, b_result=0x060 → b_valid high 1 cycle after req handshake; out_valid next cycle with out_op=6, out_result=0x060, out_cnt=3; occ→2.
- Back-pressure: out_ready=0, issue DEPTH=4 requests with b_ready=1 → 4 results buffered, out_level=4, req_ready=0 with req_valid held high; one pop → req_ready=1 next cycle; no result lost, order preserved.
- b_ready stall: hold b_ready=0 for 5 cycles after issue → b_valid and b_operation stable throughout; exactly one push after the b handshake.
- Occupancy saturation and underflow: 10 a_hs with no b → occ=8; then 9 b handshakes (op=0) → out_cnt tags 8,7,…,1,0; occ stays 0 after the last.
- Simultaneous a_hs and b_hs with occ=5 → tag 5, occ remains 5. Simultaneous push and pop at out_level=2 → level stays 2.
- Reset mid-ISSUE, with b_valid=1 and 3 entries buffered → b_valid=0, out_valid=0, out_level=0 and req_ready=0 immediately; req_ready=1 on the first edge after rstn deasserts.
